// File: rtl/ks_pkg.sv
// ks_pkg -- shared types and sizing helpers for the Kogge-Stone pipelined adder.
//   levels(width)          : number of prefix levels, log2(width)
//   lat(width, pipe_every) : register stages from operand accept to result
//   gp_t                   : packed (generate, propagate) pair used by prefix cells
package ks_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int levels(input int width);
        return $clog2(width);
    endfunction

    function automatic int lat(input int width, input int pipe_every);
        return 1 + (levels(width) + pipe_every - 1) / pipe_every;
    endfunction

endpackage

// File: rtl/ks_prefix_cell.sv
// ks_prefix_cell -- one Kogge-Stone prefix operator.
//   hi_i : (g,p) of the more significant group
//   lo_i : (g,p) of the adjacent less significant group
//   gp_o : combined group (g,p); a gray cell produces G only (P driven 0)
module ks_prefix_cell
    import ks_pkg::*;
#(
    parameter bit GRAY = 1'b0
) (
    input  gp_t hi_i,
    input  gp_t lo_i,
    output gp_t gp_o
);

    logic p_w;
    logic unused_lo_p;

    // A gray cell's span already reaches the carry-in, so its group
    // propagate is never consumed downstream.
    if (GRAY) begin : g_gray
        assign p_w         = 1'b0;
        assign unused_lo_p = lo_i.p;
    end else begin : g_black
        assign p_w         = hi_i.p & lo_i.p;
        assign unused_lo_p = 1'b0;
    end

    assign gp_o = '{g: hi_i.g | (hi_i.p & lo_i.g), p: p_w};

endmodule

// File: rtl/ks_pipe_adder.sv
// ks_pipe_adder -- pipelined Kogge-Stone adder/subtractor with valid/ready.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (in_ready = global advance)
//   a, b, cin, sub      : operands; sub=1 computes a + ~b + 1, cin ignored
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result mod 2^WIDTH, carry out (1 = no borrow), signed overflow
// Stage 1 registers p/g; a register slice follows every PIPE_EVERY prefix
// levels; the final level feeds the output register.
module ks_pipe_adder
    import ks_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = levels(WIDTH);
    // Prefix node 0 is bit position -1 holding the carry-in as its generate,
    // so node j's final generate is the carry into bit j.
    localparam int NW = WIDTH + 1;

    // Single global advance: every stage shifts together, bubbles included.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ---------------- stage 1: operand conditioning ----------------
    logic [WIDTH-1:0] bx;
    logic             c0;
    assign bx = sub ? ~b : b;
    assign c0 = sub | cin;

    logic             s1_v_q;
    logic [NW-1:0]    s1_g_q;
    logic [WIDTH-1:0] s1_p_q;
    logic [1:0]       s1_msb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s1_g_q   <= '0;
            s1_p_q   <= '0;
            s1_msb_q <= '0;
        end else if (adv) begin
            s1_v_q   <= in_valid;
            s1_g_q   <= {a & bx, c0};
            s1_p_q   <= a ^ bx;
            s1_msb_q <= {a[WIDTH-1], bx[WIDTH-1]};
        end
    end

    // ---------------- prefix tree ----------------
    // li_* : inputs of level k (after any register slice); lg/lp : outputs.
    logic [LEVELS-1:0][NW-1:0]    li_g, li_p, lg, lp;
    logic [LEVELS-1:0][WIDTH-1:0] li_pv;
    logic [LEVELS-1:0][1:0]       li_msb;
    logic [LEVELS-1:0]            li_v;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        if (k == 0) begin : g_src
            assign li_g[k]   = s1_g_q;
            assign li_p[k]   = {s1_p_q, 1'b0};
            assign li_pv[k]  = s1_p_q;
            assign li_msb[k] = s1_msb_q;
            assign li_v[k]   = s1_v_q;
        end else if (k % PIPE_EVERY == 0) begin : g_reg
            logic [NW-1:0]    g_q, p_q;
            logic [WIDTH-1:0] pv_q;
            logic [1:0]       msb_q;
            logic             v_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    g_q   <= '0;
                    p_q   <= '0;
                    pv_q  <= '0;
                    msb_q <= '0;
                    v_q   <= 1'b0;
                end else if (adv) begin
                    g_q   <= lg[k-1];
                    p_q   <= lp[k-1];
                    pv_q  <= li_pv[k-1];
                    msb_q <= li_msb[k-1];
                    v_q   <= li_v[k-1];
                end
            end
            assign li_g[k]   = g_q;
            assign li_p[k]   = p_q;
            assign li_pv[k]  = pv_q;
            assign li_msb[k] = msb_q;
            assign li_v[k]   = v_q;
        end else begin : g_thru
            assign li_g[k]   = lg[k-1];
            assign li_p[k]   = lp[k-1];
            assign li_pv[k]  = li_pv[k-1];
            assign li_msb[k] = li_msb[k-1];
            assign li_v[k]   = li_v[k-1];
        end

        for (genvar j = 0; j < NW; j++) begin : g_node
            if (j < (1 << k)) begin : g_pass
                // already resolved down to the carry-in
                assign lg[k][j] = li_g[k][j];
                assign lp[k][j] = li_p[k][j];
            end else begin : g_cell
                gp_t hi, lo, r;
                assign hi = '{g: li_g[k][j],          p: li_p[k][j]};
                assign lo = '{g: li_g[k][j-(1 << k)], p: li_p[k][j-(1 << k)]};
                // lower group reaches node 0 exactly when j < 2^(k+1)
                ks_prefix_cell #(.GRAY(j < (2 << k))) u_cell (
                    .hi_i (hi),
                    .lo_i (lo),
                    .gp_o (r)
                );
                assign lg[k][j] = r.g;
                assign lp[k][j] = r.p;
            end
        end
    end

    logic unused_last_p;
    assign unused_last_p = ^lp[LEVELS-1];

    // ---------------- output stage ----------------
    logic [NW-1:0]    c;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d, ovf_d;
    logic [1:0]       msb_l;

    assign c      = lg[LEVELS-1];
    assign msb_l  = li_msb[LEVELS-1];
    assign sum_d  = li_pv[LEVELS-1] ^ c[WIDTH-1:0];
    assign cout_d = c[WIDTH];
    assign ovf_d  = (msb_l[1] ~^ msb_l[0]) & (sum_d[WIDTH-1] ^ msb_l[1]);

    logic             out_valid_q, cout_q, ovf_q;
    logic [WIDTH-1:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= li_v[LEVELS-1];
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ks_pipe_adder.sv
module tb_ks_pipe_adder;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT 32/2 (LAT 4), 8/1 (LAT 4), 64/3 (LAT 3)
    logic        iv32, ir32, cin32, sub32, ov32, or32, co32, ovf32;
    logic [31:0] a32, b32, sum32;
    logic        iv8, ir8, cin8, sub8, ov8, or8, co8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        iv64, ir64, cin64, sub64, ov64, or64, co64, ovf64;
    logic [63:0] a64, b64, sum64;

    ks_pipe_adder #(.WIDTH(32), .PIPE_EVERY(2)) u_d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
        .cout(co32), .ovf(ovf32));
    ks_pipe_adder #(.WIDTH(8), .PIPE_EVERY(1)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
        .cout(co8), .ovf(ovf8));
    ks_pipe_adder #(.WIDTH(64), .PIPE_EVERY(3)) u_d64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
        .cin(cin64), .sub(sub64), .out_valid(ov64), .out_ready(or64), .sum(sum64),
        .cout(co64), .ovf(ovf64));

    exp_t q32[$], q8[$], q64[$];
    int   checks = 0;
    int   errors = 0;
    int   got32 = 0, acc32 = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // behavioural reference: {cout,sum} = a + b' + c0
    function automatic exp_t model(input int w, input logic [63:0] ta, input logic [63:0] tb_,
                                   input logic tc, input logic ts);
        logic [64:0] full;
        logic [63:0] mask, am, bb;
        exp_t e;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am     = ta & mask;
        bb     = (ts ? ~tb_ : tb_) & mask;
        full   = {1'b0, am} + {1'b0, bb} + 65'(ts ? 1'b1 : tc);
        e.sum  = full[63:0] & mask;
        e.cout = full[w];
        e.ovf  = (am[w-1] == bb[w-1]) && (e.sum[w-1] != am[w-1]);
        return e;
    endfunction

    // One cycle: at negedge+1 score outputs being consumed and record accepted
    // operands, then advance to the next negedge.
    task automatic tick();
        exp_t e;
        #1;
        if (ov32 && or32) begin
            check("sb32_nonempty", 64'(q32.size() != 0), 64'd1);
            if (q32.size() != 0) begin
                e = q32.pop_front();
                check("sb32_sum", 64'(sum32), e.sum);
                check("sb32_cout", 64'(co32), 64'(e.cout));
                check("sb32_ovf", 64'(ovf32), 64'(e.ovf));
                got32++;
            end
        end
        if (iv32 && ir32) begin
            q32.push_back(model(32, 64'(a32), 64'(b32), cin32, sub32));
            acc32++;
        end
        if (ov8 && or8) begin
            check("sb8_nonempty", 64'(q8.size() != 0), 64'd1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("sb8_sum", 64'(sum8), e.sum);
                check("sb8_cout", 64'(co8), 64'(e.cout));
                check("sb8_ovf", 64'(ovf8), 64'(e.ovf));
            end
        end
        if (iv8 && ir8) q8.push_back(model(8, 64'(a8), 64'(b8), cin8, sub8));
        if (ov64 && or64) begin
            check("sb64_nonempty", 64'(q64.size() != 0), 64'd1);
            if (q64.size() != 0) begin
                e = q64.pop_front();
                check("sb64_sum", sum64, e.sum);
                check("sb64_cout", 64'(co64), 64'(e.cout));
                check("sb64_ovf", 64'(ovf64), 64'(e.ovf));
            end
        end
        if (iv64 && ir64) q64.push_back(model(64, a64, b64, cin64, sub64));
        @(negedge clk);
    endtask

    task automatic send32(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tc, input logic ts,
                          input logic [31:0] es, input logic ec, input logic eo);
        int n;
        iv32 = 1'b1; a32 = ta; b32 = tb_; cin32 = tc; sub32 = ts; or32 = 1'b1;
        tick();
        iv32 = 1'b0;
        n = 1;
        while (!ov32 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd4);
        check({tag, "_sum"}, 64'(sum32), 64'(es));
        check({tag, "_cout"}, 64'(co32), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf32), 64'(eo));
        tick();
    endtask

    task automatic probe(input int sel, input int exp_lat, input string tag);
        int n;
        a8 = 8'($urandom); b8 = 8'($urandom); a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
        if (sel == 8) iv8 = 1'b1; else iv64 = 1'b1;
        tick();
        iv8 = 1'b0; iv64 = 1'b0;
        n = 1;
        while (!((sel == 8) ? ov8 : ov64) && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(n), 64'(exp_lat));
        tick();
    endtask

    initial begin
        int   b_acc, b_got, stall_left;
        logic first;
        logic [31:0] hold_sum;
        logic hold_co;

        rst_n = 1'b0;
        iv32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; or32 = 1;
        iv8  = 0; a8  = 0; b8  = 0; cin8  = 0; sub8  = 0; or8  = 1;
        iv64 = 0; a64 = 0; b64 = 0; cin64 = 0; sub64 = 0; or64 = 1;
        @(negedge clk);
        @(negedge clk);
        check("rst_ov32", 64'(ov32), 64'd0);
        check("rst_sum32", 64'(sum32), 64'd0);
        check("rst_cout32", 64'(co32), 64'd0);
        check("rst_ovf32", 64'(ovf32), 64'd0);
        check("rst_ov8", 64'(ov8), 64'd0);
        check("rst_ov64", 64'(ov64), 64'd0);
        rst_n = 1'b1;
        #1 check("rst_inrdy32", 64'(ir32), 64'd1);
        @(negedge clk);

        // directed vectors
        send32("wrap",   32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        send32("ovfadd", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        send32("ovfsub", 32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        send32("borrow", 32'h5,        32'h7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        send32("cinadd", 32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h21436588, 1'b0, 1'b0);

        probe(8, 4, "lat8");
        probe(64, 3, "lat64");

        // back-pressure: 8 ops, stall 6 cycles after the second result
        b_acc = acc32; b_got = got32; stall_left = 6; first = 1'b1;
        hold_sum = '0; hold_co = 1'b0;
        for (int cyc = 0; cyc < 80 && (got32 - b_got) < 8; cyc++) begin
            iv32 = (acc32 - b_acc) < 8;
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
            if ((got32 - b_got) >= 2 && stall_left > 0) begin
                or32 = 1'b0;
                stall_left--;
                #1;
                check("bp_outvalid", 64'(ov32), 64'd1);
                check("bp_inready", 64'(ir32), 64'd0);
                if (first) begin
                    hold_sum = sum32; hold_co = co32; first = 1'b0;
                end else begin
                    check("bp_sum_hold", 64'(sum32), 64'(hold_sum));
                    check("bp_cout_hold", 64'(co32), 64'(hold_co));
                end
            end else begin
                or32 = 1'b1;
            end
            tick();
        end
        iv32 = 1'b0; or32 = 1'b1;
        check("bp_results", 64'(got32 - b_got), 64'd8);
        check("bp_stalled", 64'(stall_left), 64'd0);
        check("bp_sb_empty", 64'(q32.size()), 64'd0);

        // reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            iv32 = 1'b1; a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
            tick();
        end
        iv32 = 1'b0;
        tick();
        check("rst_pre_valid", 64'(ov32), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_drop", 64'(ov32), 64'd0);
        q32.delete(); q8.delete(); q64.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("rst_no_stale", 64'(ov32), 64'd0);
            check("rst_inready", 64'(ir32), 64'd1);
            tick();
        end

        // random sweep on all three configurations
        for (int cyc = 0; cyc < 400; cyc++) begin
            iv32 = 1'($urandom); or32 = ($urandom_range(0, 3) != 0);
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
            iv8 = 1'($urandom); or8 = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
            iv64 = 1'($urandom); or64 = ($urandom_range(0, 3) != 0);
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            cin64 = 1'($urandom); sub64 = 1'($urandom);
            tick();
        end
        iv32 = 1'b0; iv8 = 1'b0; iv64 = 1'b0;
        or32 = 1'b1; or8 = 1'b1; or64 = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("drain32", 64'(q32.size()), 64'd0);
        check("drain8", 64'(q8.size()), 64'd0);
        check("drain64", 64'(q64.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
